led_fade_driver: RTL and testbench

Downstream consumer of the two-LED blinker outputs. Turns each on/off LED request into a PWM-dimmed pin drive that ramps brightness up or down over time instead of switching hard. One instance per board; its outputs go directly to the LED pins. All inputs are synchronous to clk.

---
 rtl/led_fade_driver.sv | 129 ++++++++++++
 tb/tb_led_fade_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade_driver
//  Description : Two-channel LED brightness fader. Each on/off request drives
//                a brightness level that ramps one count per fade step (or
//                snaps when fading is disabled); each level is turned into a
//                PWM pin drive by comparing against a shared free-running
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_fade_driver #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_DIV    = 62500,
    parameter int DIV_BITS    = 16,
    parameter bit OUT_ACT_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic led_in_1,
    input  logic led_in_2,
    input  logic fade_en,
    output logic led_out_1,
    output logic led_out_2,
    output logic busy
);

    localparam logic [PWM_BITS-1:0] c_MAX       = '1;
    localparam logic [PWM_BITS-1:0] c_ZERO      = '0;
    localparam logic [DIV_BITS-1:0] c_STEP_LAST = DIV_BITS'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RISE = 2'd1,
        S_ON   = 2'd2,
        S_FALL = 2'd3
    } state_t;

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [DIV_BITS-1:0] r_step_cnt;
    logic                w_step;
    logic [1:0]          w_req;
    logic [1:0]          w_raw_nxt;
    logic [1:0]          w_ramping;
    logic [1:0]          r_raw;
    logic                r_busy;

    assign w_req  = {led_in_2, led_in_1};
    assign w_step = (r_step_cnt == c_STEP_LAST);

    // Shared PWM counter and fade-step prescaler; both channels stay step-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt  <= '0;
            r_step_cnt <= '0;
        end else begin
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_step_cnt <= w_step ? '0 : r_step_cnt + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_ch
            logic [PWM_BITS-1:0] w_tgt;
            logic [PWM_BITS-1:0] w_lvl_nxt;
            logic [PWM_BITS-1:0] r_lvl;
            state_t              r_state;
            state_t              w_state_nxt;

            // Next level: snap when fading is off, otherwise move one count
            // toward the target on step edges. Moving only toward a target in
            // [0, MAX] means the arithmetic can never wrap.
            always_comb begin
                w_tgt     = w_req[i] ? c_MAX : c_ZERO;
                w_lvl_nxt = r_lvl;
                if (!fade_en) begin
                    w_lvl_nxt = w_tgt;
                end else if (w_step) begin
                    if (r_lvl < w_tgt) begin
                        w_lvl_nxt = r_lvl + 1'b1;
                    end else if (r_lvl > w_tgt) begin
                        w_lvl_nxt = r_lvl - 1'b1;
                    end
                end
            end

            // Channel state follows from the level/target pair being loaded.
            always_comb begin
                w_state_nxt = S_OFF;
                if (w_tgt == c_MAX) begin
                    w_state_nxt = (w_lvl_nxt == c_MAX) ? S_ON : S_RISE;
                end else begin
                    w_state_nxt = (w_lvl_nxt == c_ZERO) ? S_OFF : S_FALL;
                end
            end

            // Level and state registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lvl   <= '0;
                    r_state <= S_OFF;
                end else begin
                    r_lvl   <= w_lvl_nxt;
                    r_state <= w_state_nxt;
                end
            end

            // Full scale forces a constant high so MAX is truly 100 % duty.
            assign w_raw_nxt[i] = (r_lvl == c_MAX) || (r_lvl > r_pwm_cnt);
            assign w_ramping[i] = (r_state == S_RISE) || (r_state == S_FALL);
        end
    endgenerate

    // Registered PWM compare results and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_raw  <= w_raw_nxt;
            r_busy <= |w_ramping;
        end
    end

    assign led_out_1 = r_raw[0] ^ OUT_ACT_LOW;
    assign led_out_2 = r_raw[1] ^ OUT_ACT_LOW;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_fade_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_fade_driver
//  Description : Self-checking bench for led_fade_driver (PWM_BITS=4,
//                STEP_DIV=4). A behavioural model tracks brightness per
//                channel and the edge count since reset; outputs are compared
//                every falling edge, plus table vectors and directed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_fade_driver;

    localparam int PWM_BITS = 4;
    localparam int STEP_DIV = 4;
    localparam int MAXV     = 15;
    localparam int PERIOD   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led_in_1 = 1'b0;
    logic led_in_2 = 1'b0;
    logic fade_en = 1'b0;
    logic led_out_1;
    logic led_out_2;
    logic busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int m_lvl [2];
    bit m_ramp [2];
    bit m_raw [2];
    bit m_busy;
    int m_k;

    led_fade_driver #(
        .PWM_BITS   (PWM_BITS),
        .STEP_DIV   (STEP_DIV),
        .DIV_BITS   (2),
        .OUT_ACT_LOW(1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .led_in_1 (led_in_1),
        .led_in_2 (led_in_2),
        .fade_en  (fade_en),
        .led_out_1(led_out_1),
        .led_out_2(led_out_2),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: edge k after reset sees PWM phase k mod 16 and is a
    // fade step when k mod STEP_DIV is the last count.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = 0;
            m_busy = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_lvl[i] = 0; m_ramp[i] = 1'b0; m_raw[i] = 1'b0;
            end
        end else begin
            bit stp;
            int ph;
            int tgt;
            stp = ((m_k % STEP_DIV) == STEP_DIV - 1);
            ph  = m_k % PERIOD;
            m_busy = m_ramp[0] | m_ramp[1];
            for (int i = 0; i < 2; i++) begin
                m_raw[i] = (m_lvl[i] == MAXV) || (m_lvl[i] > ph);
                tgt = ((i == 0) ? led_in_1 : led_in_2) ? MAXV : 0;
                if (!fade_en) m_lvl[i] = tgt;
                else if (stp) begin
                    if (m_lvl[i] < tgt) m_lvl[i]++;
                    else if (m_lvl[i] > tgt) m_lvl[i]--;
                end
                m_ramp[i] = (m_lvl[i] != tgt);
            end
            m_k++;
        end
    end

    task automatic check(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out1", led_out_1, m_raw[0]);
            check("cyc_out2", led_out_2, m_raw[1]);
            check("cyc_busy", busy, m_busy);
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_lvl(input int ch, input int val, input string name);
        int n = 0;
        while (m_lvl[ch] != val && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (m_lvl[ch] != val) begin
            bad++;
            $display("FAIL %s timeout lvl=%0d exp=%0d", name, m_lvl[ch], val);
        end
    endtask

    typedef struct {
        bit fade; bit l1; bit l2; int cyc;
        bit o1; bit o2; bit bz;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 1, 0, 3, 1, 0, 0};
        vecs[1] = '{0, 0, 1, 3, 0, 1, 0};
        vecs[2] = '{0, 1, 1, 3, 1, 1, 0};
        vecs[3] = '{0, 0, 0, 3, 0, 0, 0};
        vecs[4] = '{1, 1, 0, 70, 1, 0, 0};
        vecs[5] = '{1, 1, 1, 70, 1, 1, 0};
        vecs[6] = '{1, 0, 0, 70, 0, 0, 0};
        vecs[7] = '{0, 1, 1, 3, 1, 1, 0};

        // 1. Reset holds outputs low even with a request present
        led_in_1 = 1'b1;
        cycles(3);
        check("rst_out1", led_out_1, 1'b0);
        check("rst_busy", busy, 1'b0);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("snap_edge1_out1", led_out_1, 1'b0);
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            check("snap_const_out1", led_out_1, 1'b1);
            check("snap_busy", busy, 1'b0);
        end

        // Table vectors: settle and compare steady-state outputs
        for (int v = 0; v < 8; v++) begin
            fade_en = vecs[v].fade; led_in_1 = vecs[v].l1; led_in_2 = vecs[v].l2;
            cycles(vecs[v].cyc);
            check("vec_out1", led_out_1, vecs[v].o1);
            check("vec_out2", led_out_2, vecs[v].o2);
            check("vec_busy", busy, vecs[v].bz);
        end

        // 2/3. Fade up then reverse at lvl 6
        fade_en = 1'b0; led_in_1 = 1'b0; led_in_2 = 1'b0;
        cycles(3);
        fade_en = 1'b1; led_in_1 = 1'b1;
        cycles(2);
        check("rise_busy", busy, 1'b1);
        wait_lvl(0, 6, "rev_reach6");
        led_in_1 = 1'b0;
        wait_lvl(0, 0, "rev_reach0");
        check("rev_busy_at0", busy, 1'b1);
        cycles(2);
        check("rev_busy_done", busy, 1'b0);

        // 4. Snap mid-ramp on channel 2
        led_in_2 = 1'b1;
        wait_lvl(1, 9, "snap_reach9");
        fade_en = 1'b0;
        @(negedge clk);
        check("snap2_busy_e1", busy, 1'b1);
        @(negedge clk);
        check("snap2_busy_e2", busy, 1'b0);
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            check("snap2_const", led_out_2, 1'b1);
        end

        // 5. Crossfade: ch1 full, ch2 off, then swap
        led_in_1 = 1'b1; led_in_2 = 1'b0;
        cycles(3);
        fade_en = 1'b1; led_in_1 = 1'b0; led_in_2 = 1'b1;
        begin
            int n = 0;
            cycles(2);
            while (busy && n < 100) begin
                @(negedge clk);
                n++;
                if (m_lvl[0] + m_lvl[1] != MAXV) begin
                    bad++;
                    $display("FAIL xfade_sum model=%0d", m_lvl[0] + m_lvl[1]);
                end
            end
            check("xfade_done", busy, 1'b0);
        end
        cycles(2);
        check("xfade_out1", led_out_1, 1'b0);
        check("xfade_out2", led_out_2, 1'b1);

        // 6. Asynchronous reset mid-ramp
        led_in_1 = 1'b1; led_in_2 = 1'b0;
        wait_lvl(0, 7, "arst_reach7");
        #2 rst = 1'b1;
        #1;
        check("arst_out1", led_out_1, 1'b0);
        check("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycles(2);
        check("arst_restart_busy", busy, 1'b1);
        check("arst_restart_out1", led_out_1, 1'b0);

        // Randomized stimulus checked cycle by cycle against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) led_in_1 = ~led_in_1;
            if ($urandom_range(0, 39) == 0) led_in_2 = ~led_in_2;
            fade_en = ($urandom_range(0, 31) != 0);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
